layer1_pool_writer: RTL and testbench

LAYER1_POOL_WRITER -- requirements
Module: layer1_pool_writer

---
 rtl/layer1_pkg.sv | 23 ++
 rtl/layer1_pool_writer_if.sv | 27 ++
 rtl/pool_line_buf.sv | 42 ++++
 rtl/layer1_pool_writer.sv | 117 +++++++++++
 tb/tb_layer1_pool_writer.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/layer1_pkg.sv
// Shared layer-1 geometry for the pooled-map writer and the layer1_data reader.
// The pooled maps are packed back to back in one RAM, indexed by map number.
package layer1_pkg;

    localparam int IN_W     = 24;
    localparam int OUT_W    = IN_W / 2;
    localparam int MAP_SIZE = OUT_W * OUT_W;
    localparam int ADDR_W   = 13;
    localparam int NUM_W    = 5;

    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic  we;
        addr_t addr;
        logic  data;
    } ram_wr_t;

    function automatic addr_t map_base(input logic [NUM_W-1:0] num);
        return addr_t'(int'(num) * MAP_SIZE);
    endfunction

endpackage

// File: rtl/layer1_pool_writer_if.sv
// Pixel stream in, layer1_data port-A writes out, plus start/busy/done control.
// master drives the pixel side; slave is the pool writer itself.
interface layer1_pool_writer_if;
    import layer1_pkg::*;

    logic             start;
    logic [NUM_W-1:0] num;
    logic             in_valid;
    logic             in_data;
    logic             in_ready;
    logic             wea;
    addr_t            addra;
    logic             dina;
    logic             busy;
    logic             done;

    modport master (
        output start, num, in_valid, in_data,
        input  in_ready, wea, addra, dina, busy, done
    );

    modport slave (
        input  start, num, in_valid, in_data,
        output in_ready, wea, addra, dina, busy, done
    );

endinterface

// File: rtl/pool_line_buf.sv
// One-row line buffer for 2x2 binary max pooling: even rows store pair ORs,
// odd rows combine them with the current pair and flag a finished window.
module pool_line_buf #(
    parameter int OUT_W = layer1_pkg::OUT_W,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             px_acc,
    input  logic             px_data,
    input  logic             row_odd,
    input  logic [CNT_W-1:0] col,
    output logic             win_valid,
    output logic             win_data
);

    logic             even_px;
    logic [OUT_W-1:0] line_q;
    logic [CNT_W-2:0] slot;
    logic             pair_or;

    assign slot    = col[CNT_W-1:1];
    assign pair_or = even_px | px_data;

    // NOTE: the line buffer is a handful of flops, not a RAM, so it is reset like any other state.
    always_ff @(posedge clk) begin
        if (rst) begin
            even_px <= 1'b0;
            line_q  <= '0;
        end else if (px_acc) begin
            if (!col[0]) begin
                even_px <= px_data;
            end else if (!row_odd) begin
                line_q[slot] <= pair_or;
            end
        end
    end

    assign win_valid = px_acc & row_odd & col[0];
    assign win_data  = line_q[slot] | pair_or;

endmodule

// File: rtl/layer1_pool_writer.sv
// Streams one binary conv map in raster order, 2x2 max-pools it and writes the
// pooled map into layer1_data at num*MAP_SIZE, pulsing done after the last write.
module layer1_pool_writer #(
    parameter int IN_W     = layer1_pkg::IN_W,
    parameter int OUT_W    = layer1_pkg::OUT_W,
    parameter int MAP_SIZE = layer1_pkg::MAP_SIZE
) (
    input  logic                 clk,
    input  logic                 rst,
    layer1_pool_writer_if.slave  bus
);

    localparam int CNT_W = $clog2(IN_W);
    localparam int AW    = layer1_pkg::ADDR_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;

    logic [1:0]                     state;
    logic [layer1_pkg::NUM_W-1:0]   num_q;
    logic [CNT_W-1:0]               r_cnt;
    logic [CNT_W-1:0]               c_cnt;
    layer1_pkg::ram_wr_t            wr_q;
    logic                           done_q;

    logic                           px_acc;
    logic                           last_col;
    logic                           last_px;
    logic                           win_valid;
    logic                           win_data;
    layer1_pkg::addr_t              wr_addr;

    assign px_acc   = bus.in_valid && (state == S_RUN);
    assign last_col = (c_cnt == CNT_W'(IN_W - 1));
    assign last_px  = last_col && (r_cnt == CNT_W'(IN_W - 1));

    // Address of the window whose bottom-right pixel is being accepted now.
    assign wr_addr = AW'(num_q) * AW'(MAP_SIZE)
                   + AW'(OUT_W) * AW'(r_cnt >> 1)
                   + AW'(c_cnt >> 1);

    pool_line_buf #(
        .OUT_W (OUT_W),
        .CNT_W (CNT_W)
    ) u_line_buf (
        .clk       (clk),
        .rst       (rst),
        .px_acc    (px_acc),
        .px_data   (bus.in_data),
        .row_odd   (r_cnt[0]),
        .col       (c_cnt),
        .win_valid (win_valid),
        .win_data  (win_data)
    );

    // NOTE: sequential state uses <= so every flop sees pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            num_q  <= '0;
            r_cnt  <= '0;
            c_cnt  <= '0;
            wr_q   <= '0;
            done_q <= 1'b0;
        end else begin
            wr_q.we <= 1'b0;
            done_q  <= 1'b0;

            case (state)
                S_IDLE: begin
                    // A start coinciding with done belongs to the map just finished.
                    if (bus.start && !done_q) begin
                        num_q <= bus.num;
                        r_cnt <= '0;
                        c_cnt <= '0;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (px_acc) begin
                        if (last_col) begin
                            c_cnt <= '0;
                            r_cnt <= last_px ? '0 : r_cnt + 1'b1;
                        end else begin
                            c_cnt <= c_cnt + 1'b1;
                        end
                        if (last_px) begin
                            state <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    state  <= S_IDLE;
                    done_q <= 1'b1;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase

            if (win_valid) begin
                wr_q.we   <= 1'b1;
                wr_q.addr <= wr_addr;
                wr_q.data <= win_data;
            end
        end
    end

    assign bus.in_ready = (state == S_RUN);
    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_q;
    assign bus.wea      = wr_q.we;
    assign bus.addra    = wr_q.addr;
    assign bus.dina     = wr_q.data;

endmodule

// File: tb/tb_layer1_pool_writer.sv
// Self-checking bench for layer1_pool_writer: a table of map vectors plus hand
// sequences for reset abort, ignored starts and done/start overlap.
module tb_layer1_pool_writer;
    import layer1_pkg::*;

    localparam int NPIX = IN_W * IN_W;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    layer1_pool_writer_if bus ();

    layer1_pool_writer #(
        .IN_W     (IN_W),
        .OUT_W    (OUT_W),
        .MAP_SIZE (MAP_SIZE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              data;
    } wr_rec_t;

    typedef struct {
        string name;
        int    num;
        int    pat;
        int    gap;
        int    first;
        int    last;
        int    ones;
    } vec_t;

    int      tests_run    = 0;
    int      tests_failed = 0;
    bit      img [NPIX];
    wr_rec_t got[$];
    wr_rec_t exp_q[$];
    vec_t    vecs[6];

    int n_done;
    int last_wea_cyc;
    int done_cyc;
    logic busy_at_done;
    logic busy_at_last_wea;
    logic busy_end;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // pat: 0 all zero, 1 only (1,1), 2 only (23,23), 3 checkerboard, 4 sparse random
    task automatic fill_img(input int pat);
        for (int r = 0; r < IN_W; r++) begin
            for (int c = 0; c < IN_W; c++) begin
                case (pat)
                    1:       img[r*IN_W+c] = (r == 1 && c == 1);
                    2:       img[r*IN_W+c] = (r == IN_W-1 && c == IN_W-1);
                    3:       img[r*IN_W+c] = ((r + c) % 2 == 1);
                    4:       img[r*IN_W+c] = ($urandom_range(0, 5) == 0);
                    default: img[r*IN_W+c] = 1'b0;
                endcase
            end
        end
    endtask

    // Reference: every 2x2 window whose last pixel lies below max_px, in pooled raster order.
    task automatic build_expected(input int n, input int max_px);
        wr_rec_t e;
        exp_q.delete();
        for (int pr = 0; pr < OUT_W; pr++) begin
            for (int pc = 0; pc < OUT_W; pc++) begin
                if ((2*pr+1)*IN_W + 2*pc + 1 < max_px) begin
                    e.addr = ADDR_W'(n*MAP_SIZE + OUT_W*pr + pc);
                    e.data = img[(2*pr)*IN_W+2*pc]   | img[(2*pr)*IN_W+2*pc+1]
                           | img[(2*pr+1)*IN_W+2*pc] | img[(2*pr+1)*IN_W+2*pc+1];
                    exp_q.push_back(e);
                end
            end
        end
    endtask

    // gap: 0 continuous, 1 toggle every cycle, 2 random gaps.
    task automatic run_map(input logic [NUM_W-1:0] n, input int gap, input int rst_after,
                           input bit mid_start, input bit done_start);
        int      idx;
        int      cyc;
        int      rst_cyc;
        bit      mid_done;
        bit      acc;
        wr_rec_t rec;
        idx = 0; cyc = 0; rst_cyc = -1; mid_done = 0;
        got.delete();
        n_done = 0; last_wea_cyc = -10; done_cyc = -1;
        busy_at_done = 1'bx; busy_at_last_wea = 1'bx;

        // Valid pixels while IDLE must be ignored.
        @(negedge clk);
        bus.in_valid = 1'b1; bus.in_data = 1'b1;
        bus.start = 1'b1; bus.num = n;
        @(negedge clk);
        bus.num = NUM_W'($urandom);

        while (cyc < 4000) begin
            if (bus.wea === 1'b1) begin
                rec.addr = bus.addra; rec.data = bus.dina;
                got.push_back(rec);
                last_wea_cyc = cyc;
                busy_at_last_wea = bus.busy;
            end
            if (bus.done === 1'b1) begin
                n_done++;
                done_cyc = cyc;
                busy_at_done = bus.busy;
            end
            if (done_cyc >= 0 && cyc >= done_cyc + 4) break;
            if (rst_cyc >= 0 && cyc >= rst_cyc + 10) break;

            bus.start = 1'b0;
            rst = 1'b0;
            if (rst_after >= 0 && rst_cyc < 0 && idx == rst_after) begin
                rst = 1'b1; bus.start = 1'b1; rst_cyc = cyc;
            end
            if (mid_start && !mid_done && idx == 100) begin
                bus.start = 1'b1; bus.num = 5'd5; mid_done = 1;
            end
            if (done_start && bus.done === 1'b1) begin
                bus.start = 1'b1; bus.num = 5'd9;
            end
            if (rst_cyc < 0 && idx < NPIX) begin
                case (gap)
                    1:       bus.in_valid = (cyc % 2 == 0);
                    2:       bus.in_valid = ($urandom_range(0, 2) != 0);
                    default: bus.in_valid = 1'b1;
                endcase
                bus.in_data = bus.in_valid ? img[idx] : 1'($urandom);
            end else begin
                bus.in_valid = (rst_cyc >= 0) ? 1'b1 : 1'($urandom);
                bus.in_data  = 1'($urandom);
            end
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            if (acc && rst_cyc < 0) idx++;
            @(negedge clk);
            cyc++;
        end
        rst = 1'b0; bus.start = 1'b0; bus.in_valid = 1'b0;
        busy_end = bus.busy;
    endtask

    task automatic verify(input string nm, input int exp_done, input int exp_n,
                          input int first, input int last, input int ones);
        int n_ones;
        check({nm, ".writes"}, got.size(), exp_n);
        check({nm, ".writes_vs_model"}, got.size(), exp_q.size());
        for (int i = 0; i < got.size() && i < exp_q.size(); i++) begin
            check($sformatf("%s[%0d].addr", nm, i), got[i].addr, exp_q[i].addr);
            check($sformatf("%s[%0d].data", nm, i), got[i].data, exp_q[i].data);
        end
        if (got.size() > 0) begin
            check({nm, ".first_addr"}, got[0].addr, first);
            check({nm, ".last_addr"}, got[got.size()-1].addr, last);
        end
        if (ones >= 0) begin
            n_ones = 0;
            foreach (got[i]) n_ones += got[i].data;
            check({nm, ".ones"}, n_ones, ones);
        end
        check({nm, ".done_count"}, n_done, exp_done);
        if (exp_done > 0) begin
            check({nm, ".done_after_last_wea"}, done_cyc, last_wea_cyc + 1);
            check({nm, ".busy_at_last_wea"}, busy_at_last_wea, 1);
            check({nm, ".busy_at_done"}, busy_at_done, 0);
        end
        check({nm, ".busy_end"}, busy_end, 0);
    endtask

    initial begin
        vecs[0] = '{"zeros",      0, 0, 0,    0,  143,   0};
        vecs[1] = '{"pix_1_1",    3, 1, 0,  432,  575,   1};
        vecs[2] = '{"pix_23_23", 31, 2, 0, 4464, 4607,   1};
        vecs[3] = '{"checker",    7, 3, 1, 1008, 1151, 144};
        vecs[4] = '{"rand_cont", 10, 4, 0, 1440, 1583,  -1};
        vecs[5] = '{"rand_gaps", 20, 4, 2, 2880, 3023,  -1};

        bus.start = 1'b0; bus.num = '0; bus.in_valid = 1'b0; bus.in_data = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.wea",      bus.wea,      0);
        check("reset.done",     bus.done,     0);
        check("reset.busy",     bus.busy,     0);
        check("reset.in_ready", bus.in_ready, 0);
        check("reset.addra",    bus.addra,    0);
        check("reset.dina",     bus.dina,     0);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            fill_img(vecs[v].pat);
            build_expected(vecs[v].num, NPIX);
            run_map(NUM_W'(vecs[v].num), vecs[v].gap, -1, 1'b0, 1'b0);
            verify(vecs[v].name, 1, OUT_W*OUT_W, vecs[v].first, vecs[v].last, vecs[v].ones);
        end

        // Abort after 300 accepted pixels; rst coincides with start and in_valid.
        fill_img(4);
        build_expected(2, 300);
        run_map(5'd2, 0, 300, 1'b0, 1'b0);
        verify("rst_abort", 0, 72, 288, 359, -1);
        check("rst_abort.in_ready", bus.in_ready, 0);

        fill_img(4);
        build_expected(1, NPIX);
        run_map(5'd1, 0, -1, 1'b0, 1'b0);
        verify("after_rst", 1, OUT_W*OUT_W, 144, 287, -1);

        fill_img(4);
        build_expected(2, NPIX);
        run_map(5'd2, 2, -1, 1'b1, 1'b0);
        verify("mid_start", 1, OUT_W*OUT_W, 288, 431, -1);

        // start in the done cycle is dropped; the following cycle it is taken.
        fill_img(3);
        build_expected(4, NPIX);
        run_map(5'd4, 0, -1, 1'b0, 1'b1);
        verify("done_start", 1, OUT_W*OUT_W, 576, 719, 144);
        @(negedge clk);
        bus.start = 1'b1; bus.num = 5'd6;
        @(negedge clk);
        bus.start = 1'b0;
        check("restart.busy",     bus.busy,     1);
        check("restart.in_ready", bus.in_ready, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("restart_rst.busy",     bus.busy,     0);
        check("restart_rst.in_ready", bus.in_ready, 0);
        check("restart_rst.wea",      bus.wea,      0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
